// File: rtl/conv_stream_ctrl_if.sv
// Signal bundle between the frame sequencer (slave modport) and its environment
// (master modport): upstream stream, datapath pixel/result pair, tagged output stream, status.
interface conv_stream_ctrl_if #(
   parameter int WORD_SIZE = 8,
   parameter int ROW_SIZE  = 540,
   parameter int NUM_ROWS  = 540
);
   localparam int RW = $clog2(NUM_ROWS);
   localparam int CW = $clog2(ROW_SIZE);

   // Upstream handshake: a pixel transfers on a rising clk edge where in_valid and
   // in_ready are both 1; in_ready is registered and never depends on in_valid.
   logic                 start;
   logic                 in_valid;
   logic                 in_ready;
   logic [WORD_SIZE-1:0] in_pixel;
   logic [WORD_SIZE-1:0] dp_pixel;
   logic [WORD_SIZE-1:0] dp_result;
   logic                 out_valid;
   logic [WORD_SIZE-1:0] out_pixel;
   logic                 out_interior;
   logic [RW-1:0]        out_row;
   logic [CW-1:0]        out_col;
   logic                 out_last;
   logic                 busy;
   logic                 frame_done;
   logic                 underflow_err;

   modport slave (
      input  start, in_valid, in_pixel, dp_result,
      output in_ready, dp_pixel, out_valid, out_pixel, out_interior,
             out_row, out_col, out_last, busy, frame_done, underflow_err
   );

   modport master (
      output start, in_valid, in_pixel, dp_result,
      input  in_ready, dp_pixel, out_valid, out_pixel, out_interior,
             out_row, out_col, out_last, busy, frame_done, underflow_err
   );
endinterface

// File: rtl/conv_stream_ctrl.sv
// Frame sequencer for the 3x3 Laplacian datapath: feeds dp_pixel every cycle and tags
// each dp_result with valid/interior/last/centre-coordinate sideband aligned to the pipe.
module conv_stream_ctrl #(
   parameter int WORD_SIZE = 8,
   parameter int ROW_SIZE  = 540,
   parameter int NUM_ROWS  = 540,
   parameter int PIPE_LAT  = 4
) (
   input  logic              clk,
   input  logic              rst,
   conv_stream_ctrl_if.slave bus_io,
   output logic [1:0]        dbg_state_o
);
   localparam int RW = $clog2(NUM_ROWS);
   localparam int CW = $clog2(ROW_SIZE);
   localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [RW-1:0] ROW_LAST   = RW'(NUM_ROWS - 1);
   localparam logic [CW-1:0] COL_LAST   = CW'(ROW_SIZE - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_e;

   typedef struct packed {
      logic          valid;
      logic          interior;
      logic          last;
      logic [RW-1:0] crow;
      logic [CW-1:0] ccol;
   } tag_t;

   state_e               state_q;
   logic [RW-1:0]        row_q;
   logic [CW-1:0]        col_q;
   logic [DW-1:0]        drain_q;
   logic [WORD_SIZE-1:0] dp_pixel_q;
   logic                 in_ready_q;
   logic                 busy_q;
   logic                 underflow_q;
   tag_t                 tag_q [PIPE_LAT];
   tag_t                 tag_d;
   tag_t                 tail;
   logic                 accept;
   logic                 last_px;

   assign accept  = (state_q == STREAM) && bus_io.in_valid;
   assign last_px = (row_q == ROW_LAST) && (col_q == COL_LAST);

   // Windows whose newest pixel sits in column 0/1 wrap across rows: valid, not interior.
   always_comb begin
      tag_d = '0;
      if (accept) begin
         tag_d.valid    = 1'b1;
         tag_d.interior = (row_q >= RW'(2)) && (col_q >= CW'(2));
         tag_d.last     = last_px;
         if (tag_d.interior) begin
            tag_d.crow = row_q - RW'(1);
            tag_d.ccol = col_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         row_q       <= '0;
         col_q       <= '0;
         drain_q     <= '0;
         dp_pixel_q  <= '0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         underflow_q <= 1'b0;
         for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= tag_d;
         for (int i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
         unique case (state_q)
            IDLE: begin
               dp_pixel_q <= '0;
               if (bus_io.start) begin
                  state_q     <= STREAM;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b1;
                  underflow_q <= 1'b0;
                  row_q       <= '0;
                  col_q       <= '0;
               end
            end
            STREAM: begin
               if (bus_io.in_valid) begin
                  dp_pixel_q <= bus_io.in_pixel;
                  if (last_px) begin
                     state_q    <= DRAIN;
                     in_ready_q <= 1'b0;
                     drain_q    <= '0;
                     row_q      <= '0;
                     col_q      <= '0;
                  end else if (col_q == COL_LAST) begin
                     col_q <= '0;
                     row_q <= row_q + RW'(1);
                  end else begin
                     col_q <= col_q + CW'(1);
                  end
               end else begin
                  // The datapath cannot stall: push a bubble and flag the frame.
                  dp_pixel_q  <= '0;
                  underflow_q <= 1'b1;
               end
            end
            DRAIN: begin
               dp_pixel_q <= '0;
               if (drain_q == DRAIN_LAST) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  drain_q <= drain_q + DW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tail                 = tag_q[PIPE_LAT-1];
   assign bus_io.in_ready      = in_ready_q;
   assign bus_io.dp_pixel      = dp_pixel_q;
   assign bus_io.out_valid     = tail.valid;
   assign bus_io.out_pixel     = bus_io.dp_result;
   assign bus_io.out_interior  = tail.interior;
   assign bus_io.out_row       = tail.crow;
   assign bus_io.out_col       = tail.ccol;
   assign bus_io.out_last      = tail.last;
   assign bus_io.frame_done    = tail.valid & tail.last;
   assign bus_io.busy          = busy_q;
   assign bus_io.underflow_err = underflow_q;
   assign dbg_state_o          = state_q;
endmodule
